// File: rtl/StateDefs.sv
// StateDefs: shared widths and loader state encoding for the fetch unit
package StateDefs;
    localparam int IMEM_ADDR_W = 7;
    localparam int INSTR_W = 16;
    typedef enum logic [1:0] {LD_IDLE, LD_ACTIVE, LD_FULL, LD_DONE} LoadState;
    function automatic string to_string(LoadState s);
        return s == LD_IDLE ? "LD_IDLE" : s == LD_ACTIVE ? "LD_ACTIVE" : s == LD_FULL ? "LD_FULL" : "LD_DONE";
    endfunction
endpackage

// File: rtl/program_counter.sv
// program_counter: clear/increment/hold PC register; wraps naturally at 2**ADDR_W
module program_counter #(
    parameter int ADDR_W = 7
) (
    input  logic              Clk,
    input  logic              ResetN,
    input  logic              en,
    input  logic              clr,
    input  logic              up,
    output logic [ADDR_W-1:0] pc
);
    always_ff @(posedge Clk)
        if (!ResetN) pc <= '0;
        else if (en && clr) pc <= '0;
        else if (en && up) pc <= pc + 1'b1;
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC, instruction memory and IR for the control unit, plus a host program loader
module instr_fetch_unit import StateDefs::*; #(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DEPTH = 2**ADDR_W,
    parameter int DATA_W = INSTR_W
) (
    input  logic              Clk,
    input  logic              ResetN,
    input  logic              PC_clr,
    input  logic              PC_up,
    input  logic              IR_ld,
    input  logic              Load_en,
    input  logic              Load_valid,
    input  logic [DATA_W-1:0] Load_data,
    input  logic              Load_last,
    output logic              Load_ready,
    output logic [ADDR_W:0]   Load_count,
    output logic              Loaded,
    output logic              Overflow,
    output logic              Busy,
    output logic [ADDR_W-1:0] PC,
    output logic [DATA_W-1:0] IR
);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(DEPTH - 1);
    LoadState state, next_state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0] waddr;
    logic fetch_en, xfer;
    assign Load_ready = state == LD_ACTIVE;
    assign Busy = state != LD_IDLE;
    assign fetch_en = !Busy && !Load_en;
    // dropping Load_en in the same cycle as a valid word aborts without writing it
    assign xfer = Load_valid && Load_ready && Load_en;
    program_counter #(.ADDR_W(ADDR_W)) u_pc (
        .Clk(Clk), .ResetN(ResetN), .en(fetch_en), .clr(PC_clr), .up(PC_up), .pc(PC)
    );
    always_comb begin
        next_state = state;
        case (state)
            LD_IDLE:   next_state = Load_en ? LD_ACTIVE : LD_IDLE;
            LD_ACTIVE: next_state = !Load_en ? LD_IDLE :
                                    xfer && Load_last ? LD_DONE :
                                    xfer && waddr == LAST_ADDR ? LD_FULL : LD_ACTIVE;
            default:   next_state = Load_en ? state : LD_IDLE;
        endcase
    end
    always_ff @(posedge Clk)
        if (!ResetN) begin
            state <= LD_IDLE;
            waddr <= '0;
            Load_count <= '0;
            Loaded <= 1'b0;
            Overflow <= 1'b0;
            IR <= '0;
        end else begin
            state <= next_state;
            if (fetch_en && IR_ld) IR <= mem[PC];
            if (state == LD_IDLE && Load_en) begin
                waddr <= '0;
                Load_count <= '0;
                Loaded <= 1'b0;
                Overflow <= 1'b0;
            end
            if (xfer) begin
                waddr <= waddr + 1'b1;
                Load_count <= Load_count == FULL_CNT ? FULL_CNT : Load_count + 1'b1;
                if (Load_last) Loaded <= 1'b1;
            end
            if (state == LD_FULL && Load_valid) Overflow <= 1'b1;
        end
    // memory is never reset; a reset cycle suppresses the pending write
    always_ff @(posedge Clk)
        if (xfer && ResetN) mem[waddr[ADDR_W-1:0]] <= Load_data;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;
    logic Clk = 0, ResetN = 0;
    logic PC_clr = 0, PC_up = 0, IR_ld = 0;
    logic Load_en = 0, Load_valid = 0, Load_last = 0;
    logic [15:0] Load_data = '0;
    logic Load_ready, Loaded, Overflow, Busy;
    logic [7:0] Load_count;
    logic [6:0] PC;
    logic [15:0] IR;
    int checks = 0, errors = 0;
    logic [15:0] prog [4] = '{16'h1203, 16'h2014, 16'h3125, 16'h5000};

    instr_fetch_unit dut (
        .Clk(Clk), .ResetN(ResetN), .PC_clr(PC_clr), .PC_up(PC_up), .IR_ld(IR_ld),
        .Load_en(Load_en), .Load_valid(Load_valid), .Load_data(Load_data), .Load_last(Load_last),
        .Load_ready(Load_ready), .Load_count(Load_count), .Loaded(Loaded), .Overflow(Overflow),
        .Busy(Busy), .PC(PC), .IR(IR)
    );

    always #5 Clk = ~Clk;

    task automatic tick(input int n = 1);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_pc"}, 32'(PC), 0);
        check({tag, "_ir"}, 32'(IR), 0);
        check({tag, "_busy"}, 32'(Busy), 0);
        check({tag, "_ready"}, 32'(Load_ready), 0);
        check({tag, "_count"}, 32'(Load_count), 0);
        check({tag, "_loaded"}, 32'(Loaded), 0);
        check({tag, "_ovf"}, 32'(Overflow), 0);
    endtask

    initial begin
        tick(2);
        ResetN = 1;
        tick();
        check_reset_state("rst");
        // program load
        Load_en = 1;
        tick();
        check("ld_busy", 32'(Busy), 1);
        for (int i = 0; i < 4; i++) begin
            Load_valid = 1; Load_data = prog[i]; Load_last = (i == 3);
            check("ld_ready", 32'(Load_ready), 1);
            tick();
        end
        Load_valid = 0; Load_last = 0;
        check("ld_count", 32'(Load_count), 4);
        check("ld_loaded", 32'(Loaded), 1);
        check("ld_done_busy", 32'(Busy), 1);
        check("ld_done_ready", 32'(Load_ready), 0);
        Load_en = 0;
        tick();
        check("ld_idle_busy", 32'(Busy), 0);
        // fetch sequence
        PC_clr = 1; tick(); PC_clr = 0;
        check("clr_pc", 32'(PC), 0);
        for (int i = 0; i < 4; i++) begin
            PC_up = 1; IR_ld = 1;
            tick();
            check("fetch_ir", 32'(IR), 32'(prog[i]));
            check("fetch_pc", 32'(PC), i + 1);
        end
        PC_up = 0; IR_ld = 0;
        // priority, hold, wrap
        PC_clr = 1; PC_up = 1; tick(); PC_clr = 0;
        check("prio_pc", 32'(PC), 0);
        tick();
        check("hold_ir", 32'(IR), 16'h5000);
        check("up_pc", 32'(PC), 1);
        tick(126);
        check("pc_127", 32'(PC), 127);
        tick();
        check("pc_wrap", 32'(PC), 0);
        tick(5);
        PC_up = 0;
        check("pc_5", 32'(PC), 5);
        // freeze while loading
        Load_en = 1; PC_up = 1; IR_ld = 1;
        tick(2);
        check("frz_pc", 32'(PC), 5);
        check("frz_ir", 32'(IR), 16'h5000);
        check("frz_count", 32'(Load_count), 0);
        check("frz_loaded", 32'(Loaded), 0);
        PC_up = 0; IR_ld = 0; Load_en = 0;
        tick();
        // overflow: 130 words offered, no last
        Load_en = 1; tick();
        for (int i = 0; i < 130; i++) begin
            Load_valid = 1; Load_data = 16'hA000 + 16'(i);
            tick();
        end
        Load_valid = 0;
        check("ovf_count", 32'(Load_count), 128);
        check("ovf_ready", 32'(Load_ready), 0);
        check("ovf_flag", 32'(Overflow), 1);
        check("ovf_loaded", 32'(Loaded), 0);
        check("ovf_busy", 32'(Busy), 1);
        Load_en = 0; tick();
        check("ovf_idle", 32'(Busy), 0);
        // 128 words with last on the final address, then an extra word
        Load_en = 1; tick();
        for (int i = 0; i < 129; i++) begin
            Load_valid = 1; Load_data = 16'hB000 + 16'(i); Load_last = (i >= 127);
            tick();
        end
        Load_valid = 0; Load_last = 0;
        check("full_last_count", 32'(Load_count), 128);
        check("full_last_loaded", 32'(Loaded), 1);
        check("full_last_ovf", 32'(Overflow), 0);
        Load_en = 0; tick();
        PC_up = 1; tick(122); PC_up = 0;
        check("pc_127b", 32'(PC), 127);
        PC_up = 1; IR_ld = 1; tick();
        check("mem127", 32'(IR), 16'hB07F);
        check("mem127_pc", 32'(PC), 0);
        PC_up = 0; tick();
        IR_ld = 0;
        check("mem0", 32'(IR), 16'hB000);
        // abort after two transfers
        Load_en = 1; tick();
        for (int i = 0; i < 2; i++) begin
            Load_valid = 1; Load_data = 16'h7001 + 16'(i);
            tick();
        end
        Load_en = 0; Load_data = 16'h7FFF;
        tick();
        Load_valid = 0;
        check("abort_busy", 32'(Busy), 0);
        check("abort_loaded", 32'(Loaded), 0);
        check("abort_count", 32'(Load_count), 2);
        PC_up = 1; IR_ld = 1;
        tick(); check("abort_m0", 32'(IR), 16'h7001);
        tick(); check("abort_m1", 32'(IR), 16'h7002);
        tick(); check("abort_m2", 32'(IR), 16'hB002);
        PC_up = 0; IR_ld = 0;
        // reset in the middle of a load
        Load_en = 1; tick();
        for (int i = 0; i < 2; i++) begin
            Load_valid = 1; Load_data = 16'h6001 + 16'(i);
            tick();
        end
        ResetN = 0; Load_data = 16'h6FFF;
        tick();
        ResetN = 1; Load_en = 0; Load_valid = 0;
        check_reset_state("midrst");
        PC_up = 1; IR_ld = 1;
        tick(); check("rst_m0", 32'(IR), 16'h6001);
        tick(); check("rst_m1", 32'(IR), 16'h6002);
        tick(); check("rst_m2", 32'(IR), 16'hB002);
        PC_up = 0; IR_ld = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
